// File: rtl/fixed_point_unit.sv
// fixed_point_unit: signed Q(WIDTH-FBITS).FBITS add/sub (combinational), multiply and square root (iterative)
module fixed_point_unit #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             ready
);
    localparam int H  = WIDTH / 2;
    localparam int N  = (WIDTH + FBITS + 3) / 4;
    localparam int RB = 4 * N;
    localparam int QB = 2 * N;
    localparam int RW = QB + 4;
    localparam int CW = $clog2(N + 4);

    logic               lat_valid, done, neg, match, ge1, ge2;
    logic [1:0]         lat_op;
    logic [WIDTH-1:0]   lat_a, lat_b, ma, mb, res, prod;
    logic [H-1:0]       xa, xb;
    logic [2*WIDTH-1:0] acc, pp, acc_n, fin;
    logic [RB-1:0]      rad;
    logic [RW-1:0]      rem, r1, r2, t1, t2, rm1, rm2;
    logic [QB-1:0]      root, q1, q2;
    logic [CW-1:0]      cnt;

    // ready/result: add/sub pass straight through, engine results only while the latched request matches
    always_comb begin
        match  = lat_valid && operation == lat_op && operand_1 == lat_a && operand_2 == lat_b;
        ready  = !reset && (!operation[1] || (done && match));
        result = reset ? '0 :
                 !operation[1] ? (operation[0] ? operand_1 - operand_2 : operand_1 + operand_2) :
                 (done && match) ? res : '0;
    end

    // multiply step: partial product picked by cnt (lo*lo, lo*hi, hi*lo, hi*hi) and shifted into place
    always_comb begin
        xa    = cnt[1] ? ma[WIDTH-1:H] : ma[H-1:0];
        xb    = cnt[0] ? mb[WIDTH-1:H] : mb[H-1:0];
        prod  = {{(WIDTH-H){1'b0}}, xa} * {{(WIDTH-H){1'b0}}, xb};
        pp    = {{WIDTH{1'b0}}, prod};
        acc_n = acc + (cnt[1:0] == 2'd0 ? pp : cnt[1:0] == 2'd3 ? pp << (2 * H) : pp << H);
        fin   = neg ? -acc_n : acc_n;
    end

    // square-root step: two digit-by-digit iterations, each consuming two radicand bits
    always_comb begin
        r1  = (rem << 2) | RW'(rad[RB-1 -: 2]);
        t1  = RW'({root, 2'b01});
        ge1 = r1 >= t1;
        rm1 = ge1 ? r1 - t1 : r1;
        q1  = (root << 1) | QB'(ge1);
        r2  = (rm1 << 2) | RW'(rad[RB-3 -: 2]);
        t2  = RW'({q1, 2'b01});
        ge2 = r2 >= t2;
        rm2 = ge2 ? r2 - t2 : r2;
        q2  = (q1 << 1) | QB'(ge2);
    end

    // request latch and engine: a new request reloads, add/sub abandons, otherwise iterate until done
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_valid <= 1'b0;
            lat_op    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            done      <= 1'b0;
            cnt       <= '0;
            ma        <= '0;
            mb        <= '0;
            neg       <= 1'b0;
            acc       <= '0;
            rad       <= '0;
            rem       <= '0;
            root      <= '0;
            res       <= '0;
        end else if (!operation[1]) begin
            lat_valid <= 1'b0;
            done      <= 1'b0;
        end else if (!match) begin
            lat_valid <= 1'b1;
            lat_op    <= operation;
            lat_a     <= operand_1;
            lat_b     <= operand_2;
            done      <= 1'b0;
            cnt       <= '0;
            ma        <= operand_1[WIDTH-1] ? -operand_1 : operand_1;
            mb        <= operand_2[WIDTH-1] ? -operand_2 : operand_2;
            neg       <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
            acc       <= '0;
            rad       <= RB'(operand_1) << FBITS;
            rem       <= '0;
            root      <= '0;
        end else if (!done) begin
            cnt <= cnt + CW'(1);
            if (!lat_op[0]) begin
                acc <= acc_n;
                if (cnt == CW'(3)) begin
                    res  <= WIDTH'(fin >> FBITS);
                    done <= 1'b1;
                end
            end else begin
                rad  <= rad << 4;
                rem  <= rm2;
                root <= q2;
                if (cnt == CW'(N - 1)) begin
                    res  <= WIDTH'(q2);
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_unit.sv
// tb_fixed_point_unit: directed vectors, corner sequences and random ops against an arithmetic reference model
module tb_fixed_point_unit;
    localparam int F = 10;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        string       name;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] operand_1 = '0;
    logic [31:0] operand_2 = '0;
    logic [1:0]  operation = '0;
    logic [31:0] result;
    logic        ready;
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[12];

    always #5 clk = ~clk;

    fixed_point_unit #(.WIDTH(32), .FBITS(F)) dut (
        .clk(clk), .reset(reset), .operand_1(operand_1), .operand_2(operand_2),
        .operation(operation), .result(result), .ready(ready)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: exact signed product floored by 2^F (negate-then-slice), exact integer square root
    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          p;
        longint unsigned r, s;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return 32'(p >>> F);
            end
            default: begin
                r = 64'(a) << F;
                s = longint'($floor($sqrt(real'(r))));
                while (s * s > r) s--;
                while ((s + 1) * (s + 1) <= r) s++;
                return 32'(s);
            end
        endcase
    endfunction

    task automatic wait_ready(input int lat, input logic [31:0] exp, input string name);
        int n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(lat));
        check({name, " result"}, result, exp);
    endtask

    task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        operation = op;
        operand_1 = a;
        operand_2 = b;
        #1;
        if (!op[1]) begin
            check({name, " ready"}, 32'(ready), 32'd1);
            check({name, " result"}, result, exp);
        end else begin
            check({name, " idle"}, result | 32'(ready), 32'd0);
            wait_ready(op[0] ? 12 : 5, exp, name);
            tick();
            check({name, " hold"}, ready ? result : 32'hDEAD_BEEF, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'h0000_0400, 32'h0000_0C00, 32'h0000_1000, "add"};
        vecs[1]  = '{2'd1, 32'h0000_0400, 32'h0000_0C00, 32'hFFFF_F800, "sub"};
        vecs[2]  = '{2'd2, 32'hFFFF_F800, 32'h0000_0600, 32'hFFFF_F400, "mul_signed"};
        vecs[3]  = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, "add_wrap"};
        vecs[4]  = '{2'd2, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, "mul_zero"};
        vecs[5]  = '{2'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "sqrt_zero"};
        vecs[6]  = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 32'h001F_FFFF, "sqrt_max"};
        vecs[7]  = '{2'd2, 32'h0010_0000, 32'h0010_0000, 32'h4000_0000, "mul_big"};
        vecs[8]  = '{2'd2, 32'h0020_0000, 32'h0020_0000, 32'h0000_0000, "mul_overflow"};
        vecs[9]  = '{2'd2, 32'hFFFF_F800, 32'hFFFF_F800, 32'h0000_1000, "mul_negneg"};
        vecs[10] = '{2'd3, 32'h0000_0400, 32'h0000_0000, 32'h0000_0400, "sqrt_one"};
        vecs[11] = '{2'd1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, "sub_wrap"};

        operation = 2'd2;
        operand_1 = 32'h0000_3F00;
        operand_2 = 32'h0000_1280;
        tick();
        check("reset_mul_ready", 32'(ready), 32'd0);
        check("reset_mul_result", result, 32'd0);
        operation = 2'd0;
        #1;
        check("reset_add_out", result | 32'(ready), 32'd0);
        operation = 2'd2;
        reset = 1'b0;
        wait_ready(5, 32'h0001_2360, "mul_after_reset");

        run(2'd3, 32'h0001_8F00, 32'h0, 32'h0000_27F3, "sqrt_b2b");

        foreach (vecs[i]) run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].name);

        operation = 2'd3;
        operand_1 = 32'h0001_0000;
        operand_2 = 32'h0;
        for (int i = 0; i < 6; i++) tick();
        check("abort_sqrt_busy", 32'(ready), 32'd0);
        operand_1 = 32'h0001_8F00;
        #1;
        wait_ready(12, 32'h0000_27F3, "abort_sqrt");

        operation = 2'd2;
        operand_1 = 32'hFFFF_F800;
        operand_2 = 32'h0000_0600;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        #1;
        check("reset_mid_comb", result | 32'(ready), 32'd0);
        tick();
        check("reset_mid_edge", result | 32'(ready), 32'd0);
        reset = 1'b0;
        wait_ready(5, 32'hFFFF_F400, "mul_after_mid_reset");

        operation = 2'd2;
        operand_1 = 32'h0000_3F00;
        operand_2 = 32'h0000_1280;
        tick();
        tick();
        operation = 2'd0;
        #1;
        check("switch_add", ready ? result : 32'hDEAD_BEEF, 32'h0000_5180);
        tick();
        operation = 2'd2;
        #1;
        check("return_mul_idle", 32'(ready), 32'd0);
        wait_ready(5, 32'h0001_2360, "return_mul");

        for (int i = 0; i < 60; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a  = (i % 3 == 0) ? 32'($urandom_range(0, 32'h0001_FFFF)) : $urandom;
            b  = (i % 4 == 0) ? 32'($urandom_range(0, 32'h0000_FFFF)) : $urandom;
            if ((i % 5) == 1) a = -a;
            run(op, a, b, model(op, a, b), $sformatf("rand%0d_op%0d", i, op));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
